// File: rtl/data_mem_resp.sv
// Wait-stated data SRAM responder for the M-stage load/store port; stalls the core per access.
// Optional build macro DMEM_BYTE_WRITE_EN: when defined, stores honour wbe byte enables.
module data_mem_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbe,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err
);

    // state  | meaning
    // S_IDLE | no access in flight; en=1 accepts a request this cycle
    // S_BUSY | access in flight; cnt counts remaining stall cycles, cnt==0 is completion
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wbe_q, wbe_d;
    logic                    oor_q, oor_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [31:0]             mem [2**ADDR_WIDTH];

    logic                    accept;
    logic                    done;
    logic                    mem_we;
    logic                    req_oor;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    unused_bits;

    assign req_idx     = addr[ADDR_WIDTH+1:2];
    assign req_oor     = (addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign accept      = (state_q == S_IDLE) && en;
    assign done        = (state_q == S_BUSY) && (cnt_q == 4'd0);
    assign mem_we      = done && wr_q && !oor_q;
    assign unused_bits = ^{addr[1:0], wbe_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wbe_q   <= 4'd0;
            oor_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wbe_q   <= wbe_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == 4'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // stall is masked by reset so a held request cannot freeze the pipe during reset
    always_comb begin
        stall = rst && (accept || ((state_q == S_BUSY) && (cnt_q != 4'd0)));
        rdata = rdata_q;
        err   = err_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wbe_d   = wbe_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        err_d   = done && oor_q;
        if (accept) begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            wr_d    = memwrite;
            idx_d   = req_idx;
            wdata_d = wdata;
            wbe_d   = wbe;
            oor_d   = req_oor;
            if (!memwrite) rdata_d = req_oor ? 32'd0 : mem[req_idx];
        end else if ((state_q == S_BUSY) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Array has no reset; a pending store is cancelled because reset clears state_q.
    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef DMEM_BYTE_WRITE_EN
            for (int i = 0; i < 4; i++) begin
                if (wbe_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
`else
            mem[idx_q] <= wdata_q;
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized load/store bench for data_mem_resp against a word-array reference model.
module tb_data_mem_resp;
    localparam int AW = 10;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wbe = 4'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] ref_rdata = 32'd0;
    logic [31:0] saved;

    data_mem_resp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .en(en), .memwrite(memwrite), .addr(addr),
        .wdata(wdata), .wbe(wbe), .rdata(rdata), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
`ifdef DMEM_BYTE_WRITE_EN
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (wd & mask);
`else
        return wd;
`endif
    endfunction

    // Called at a negedge; returns at a negedge one idle cycle after completion.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input bit churn);
        bit oor;
        int idx;
        oor = (a >> (AW + 2)) != 32'd0;
        idx = int'((a >> 2) & 32'd15);
        en = 1'b1; memwrite = wr; addr = a; wdata = wd; wbe = be;
        #1 chk("stall_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        for (int k = 1; k < WC; k++) begin
            if (churn) begin
                memwrite = $urandom_range(0, 1); addr = $urandom(); wdata = $urandom();
                wbe = 4'($urandom());
            end
            #1 chk("stall_busy", {31'd0, stall}, 32'd1);
            @(negedge clk);
        end
        #1 chk("stall_done", {31'd0, stall}, 32'd0);
        if (!wr) ref_rdata = oor ? 32'd0 : ref_mem[idx];
        chk(wr ? "rdata_after_store" : "rdata_load", rdata, ref_rdata);
        en = 1'b0;
        if (wr && !oor) ref_mem[idx] = merge(ref_mem[idx], wd, be);
        @(negedge clk);
        #1 chk("err_flag", {31'd0, err}, {31'd0, oor});
        chk("stall_idle", {31'd0, stall}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int lows;
        en = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk("idle_stall", {31'd0, stall}, 32'd0);
        end
        @(negedge clk);

        for (int i = 0; i < 16; i++) access(1'b1, 32'(i * 4), $urandom(), 4'hF, 1'b0);

        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        access(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
        chk("load_deadbeef", rdata, 32'hDEADBEEF);
        access(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0);
        access(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
`ifdef DMEM_BYTE_WRITE_EN
        chk("byte_merge", rdata, 32'hDE22BE44);
`else
        chk("byte_merge", rdata, 32'h11223344);
`endif

        saved = ref_mem[0];
        access(1'b1, 32'h1000, 32'h55AA55AA, 4'hF, 1'b0);
        access(1'b0, 32'h0, 32'd0, 4'h0, 1'b0);
        chk("oor_store_dropped", rdata, saved);
        access(1'b0, 32'h1000, 32'd0, 4'h0, 1'b0);
        chk("oor_load_zero", rdata, 32'd0);

        saved = ref_mem[8];
        en = 1'b1; memwrite = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; wbe = 4'hF;
        #1 chk("rst_mid_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        ref_rdata = 32'd0;
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(1'b0, 32'h20, 32'd0, 4'h0, 1'b0);
        chk("rst_store_cancel", rdata, saved);

        access(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);

        en = 1'b1; memwrite = 1'b0; addr = 32'h10;
        lows = 0;
        for (int c = 0; c < 3 * (WC + 1); c++) begin
            #1 if (!stall) lows++;
            @(negedge clk);
        end
        en = 1'b0;
        chk("throughput", 32'(lows), 32'd3);
        ref_rdata = ref_mem[4];
        chk("throughput_rdata", rdata, ref_rdata);
        repeat (2) @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a | (32'd1 << $urandom_range(AW + 2, 31));
            access(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom()), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Memory-side responder for the CPU's M-stage data port: it services the load/store accesses the core issues (address from aluoutM, store data from writedataM, write strobe from memwriteM) and returns load data on readdataM. It models a wait-stated synchronous data SRAM and raises a stall to the hazard unit for the duration of each access, so stallM/stallW behaviour in the pipeline can be exercised against a realistic memory.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address width; memory depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, stall cycles per access; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  M stage holds a load or store this cycle.
- memwrite  in  1  1 = store, 0 = load (aluoutM/memwriteM side).
- addr  in  32  byte address; word index = addr[ADDR_WIDTH+1:2].
- wdata  in  32  store data.
- wbe  in  4  store byte enables; wbe[i] writes wdata[8i+7:8i].
- rdata  out  32  load data, registered.
- stall  out  1  freeze request to the hazard unit.
- err  out  1  out-of-range access flag, registered.

## Operation
- States: IDLE, BUSY. A 4-bit down-counter cnt and request latches (wr_q, idx_q, wdata_q, wbe_q, oor_q) are used.
- IDLE, en=0: stall=0, nothing changes.
- IDLE, en=1 (acceptance cycle T): stall=1 combinationally in the same cycle. At the end of T the block latches the request, sets oor_q = (addr[31:ADDR_WIDTH+2] != 0), sets cnt = WAIT_CYCLES-1, and enters BUSY. On a load it captures rdata <= mem[idx] at that edge, or 0 if out of range.
- BUSY, cnt != 0: stall=1, cnt decrements.
- BUSY, cnt == 0: this is the completion cycle. stall=0 and rdata is valid for the core to sample. At the end of the cycle:
  - A store with oor_q=0 writes the array under wbe_q.
  - err <= oor_q for exactly that one edge. err is otherwise 0.
  - The state returns to IDLE.
- Out-of-range stores are dropped. Out-of-range loads return 0.
- Request inputs are ignored while BUSY. Only the values latched at acceptance are used, so changes on the core side during a stall have no effect.
- rdata holds its last value until the next load is accepted. Stores do not change rdata.
- addr[1:0] is ignored, so accesses are word-aligned.
- Reset (rst=0, at any time, including mid-access) forces IDLE, cnt=0, stall=0, rdata=0, err=0 and cancels any pending store. The array contents are not cleared.

## Timing
- Reset values: stall=0, rdata=0x00000000, err=0.
- Access latency: stall is high in cycles T..T+WAIT_CYCLES-1 and low in cycle T+WAIT_CYCLES, the completion cycle.
- A store becomes visible at the end of the completion cycle. A load accepted in the following cycle (T+WAIT_CYCLES+1) returns the new value.
- Back-to-back accesses:
  - The earliest next acceptance is the cycle after completion.
  - With en held high continuously, one access completes every WAIT_CYCLES+1 cycles.
- WAIT_CYCLES=1: stall is high for exactly one cycle (T), and completion is in T+1.
- Count wrap: cnt never underflows. The transition BUSY→IDLE happens at cnt==0.

## Configuration
- DMEM_BYTE_WRITE_EN defined: stores honour wbe. Bytes with wbe[i]=0 keep their previous value, and wbe=4'b0000 performs no write but still takes the full latency.
- DMEM_BYTE_WRITE_EN undefined: wbe is ignored, and every store writes all 32 bits.

## Test plan
- Reset: hold rst=0 with en=1 → stall=0, rdata=0, err=0. Release, then idle with en=0 → stall stays 0.
- Store then load, WAIT_CYCLES=2:
  - Store addr=0x10, wdata=0xDEADBEEF, wbe=4'hF → stall high 2 cycles, low on the 3rd.
  - Load addr=0x10 → rdata=0xDEADBEEF in its completion cycle.
- Byte enables (DMEM_BYTE_WRITE_EN defined): word 0x10 = 0xDEADBEEF, store wdata=0x11223344 with wbe=4'b0101 → a later load returns 0xDE22BE44.
  - With the macro undefined, the same sequence returns 0x11223344.
- Out of range, ADDR_WIDTH=10: store to 0x00001000 → err=1 for one edge and word 0 is unchanged. Load from 0x00001000 → rdata=0 and err=1.
- Mid-access reset: accept a store to 0x20 with 0xCAFEF00D, then pull rst low in the first stall cycle → stall=0 immediately. After release, a load of 0x20 returns the pre-existing value, not 0xCAFEF00D.
- Input churn: accept a load of 0x10, then change addr to 0x40 during the stall → rdata returns the contents of 0x10.
